load_align_unit: RTL and testbench

- Multi-cycle load data path for the core's memory stage, replacing the purely combinational load extension step.
- Accepts a load request (byte address plus size/sign select) and issues one or two word-aligned reads to data memory.
- Extracts the addressed bytes, including accesses that straddle a word boundary, and returns them sign- or zero-extended.
- Parametrised in data width (32/64) and in misaligned-access support.

---
 rtl/load_align_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_align_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// load_align_unit
// Multi-cycle load path for the memory stage. A load request (byte address
// plus size/sign select) is turned into one or two word-aligned reads. The
// addressed bytes are extracted, including accesses that straddle a word
// boundary, and returned sign- or zero-extended.
//
// Ports:
//   i_clk, i_reset            rising-edge clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   load request handshake (ready only while idle)
//   i_addr, i_sl_sel          byte address and select
//                             (000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101 lwu, 110 ld)
//   o_mem_valid/i_mem_ready   word-aligned read request handshake
//   o_mem_addr                word-aligned read address
//   i_mem_rvalid/i_mem_rdata  read data return
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_data, o_rsp_err     extended load result, illegal-request flag
module load_align_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit SUPPORT_MISALIGN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_sl_sel,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    localparam int B    = DATA_W / 8;
    localparam int OFFW = $clog2(B);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WAIT0,
        RD1,
        WAIT1,
        RSP
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        sel_q;
    logic              span_q;
    logic [DATA_W-1:0] word0_q;
    logic [DATA_W-1:0] word1_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic [3:0]        req_size;
    logic              req_span;
    logic              req_illegal;

    logic [ADDR_W-1:0] aligned_addr;
    logic [DATA_W-1:0] cap_w0;
    logic [DATA_W-1:0] cap_w1;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lifted;
    logic signed [DATA_W-1:0] lifted_s;
    logic [DATA_W-1:0] ext_data;
    int                keep_bits;
    int                drop_bits;

    function automatic logic [3:0] sel_size(input logic [2:0] sel);
        case (sel)
            3'b000, 3'b011: return 4'd1;
            3'b001, 3'b100: return 4'd2;
            3'b010, 3'b101: return 4'd4;
            default:        return 4'd8;
        endcase
    endfunction

    function automatic logic sel_signed(input logic [2:0] sel);
        return (sel == 3'b000) || (sel == 3'b001) || (sel == 3'b010);
    endfunction

    // Classify the incoming request: its size, whether it crosses into the
    // next word, and whether it has to be rejected without touching memory.
    // A 64-bit select on a 32-bit core always spans, but it is already
    // rejected as an illegal select.
    always_comb begin
        req_size    = sel_size(i_sl_sel);
        req_span    = (int'(i_addr[OFFW-1:0]) + int'(req_size)) > B;
        req_illegal = (i_sl_sel == 3'b111)
                   || ((DATA_W == 32) && ((i_sl_sel == 3'b101) || (i_sl_sel == 3'b110)))
                   || (req_span && !SUPPORT_MISALIGN);
    end

    // Build the byte window for extraction. The word arriving this cycle is
    // used directly so the final result can be registered on the same edge
    // that captures it; the upper word is only meaningful for split accesses
    // and its bytes are discarded otherwise.
    always_comb begin
        cap_w0  = (state == WAIT0) ? i_mem_rdata : word0_q;
        cap_w1  = (state == WAIT1) ? i_mem_rdata : word1_q;
        shifted = DATA_W'({cap_w1, cap_w0} >> {addr_q[OFFW-1:0], 3'b000});
    end

    // Keep only the requested bytes by pushing them to the top of the word
    // and shifting back down, arithmetically for signed loads and logically
    // for unsigned ones. Full-width loads pass straight through.
    always_comb begin
        keep_bits = 8 * int'(sel_size(sel_q));
        drop_bits = (keep_bits >= DATA_W) ? 0 : (DATA_W - keep_bits);
        lifted    = shifted << drop_bits;
        lifted_s  = lifted;
        if (sel_signed(sel_q)) begin
            ext_data = lifted_s >>> drop_bits;
        end else begin
            ext_data = lifted >> drop_bits;
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Illegal requests jump straight to the response
    // state; everything else walks the read sequence, visiting the second
    // read only when the access straddles a word boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_req_valid)  state_nxt = req_illegal ? RSP : RD0;
            RD0:   if (i_mem_ready)  state_nxt = WAIT0;
            WAIT0: if (i_mem_rvalid) state_nxt = span_q ? RD1 : RSP;
            RD1:   if (i_mem_ready)  state_nxt = WAIT1;
            WAIT1: if (i_mem_rvalid) state_nxt = RSP;
            RSP:   if (i_rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Request, captured words and the registered response. Read data is
    // only taken in the two wait states, so stray returns are ignored. The
    // response is cleared once the consumer takes it.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q     <= '0;
            sel_q      <= '0;
            span_q     <= 1'b0;
            word0_q    <= '0;
            word1_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q <= i_addr;
                        sel_q  <= i_sl_sel;
                        span_q <= req_span;
                        if (req_illegal) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end
                    end
                end
                WAIT0: begin
                    if (i_mem_rvalid) begin
                        word0_q <= i_mem_rdata;
                        if (!span_q) begin
                            rsp_data_q <= ext_data;
                        end
                    end
                end
                WAIT1: begin
                    if (i_mem_rvalid) begin
                        word1_q    <= i_mem_rdata;
                        rsp_data_q <= ext_data;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs follow the state directly, so they drop to their idle values
    // the moment reset is asserted. The second read address wraps naturally
    // at the top of the address space.
    always_comb begin
        aligned_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        o_req_ready  = (state == IDLE);
        o_mem_valid  = (state == RD0) || (state == RD1);
        o_mem_addr   = '0;
        if (state == RD0) begin
            o_mem_addr = aligned_addr;
        end else if (state == RD1) begin
            o_mem_addr = aligned_addr + ADDR_W'(B);
        end
        o_rsp_valid  = (state == RSP);
        o_rsp_data   = rsp_data_q;
        o_rsp_err    = rsp_err_q;
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
// Directed bench for load_align_unit. Three copies are built: a 32-bit unit
// with split accesses enabled (index 0), a 32-bit unit that rejects
// straddling accesses (index 1) and a 64-bit unit (index 2). Each step drives
// inputs shortly after a rising edge and samples outputs at the same point.
module tb_load_align_unit;

    logic        clk;
    logic        rst_n;

    logic [2:0]  req_valid;
    logic [2:0]  mem_ready;
    logic [2:0]  mem_rvalid;
    logic [2:0]  rsp_ready;
    logic [31:0] addr      [3];
    logic [2:0]  sel       [3];
    logic [63:0] mem_rdata [3];

    logic        a_req_ready, b_req_ready, c_req_ready;
    logic        a_mem_valid, b_mem_valid, c_mem_valid;
    logic [31:0] a_mem_addr,  b_mem_addr,  c_mem_addr;
    logic        a_rsp_valid, b_rsp_valid, c_rsp_valid;
    logic        a_rsp_err,   b_rsp_err,   c_rsp_err;
    logic [31:0] a_rsp_data,  b_rsp_data;
    logic [63:0] c_rsp_data;

    int total;
    int bad;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .SUPPORT_MISALIGN(1'b1)) u_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(a_req_ready),
        .i_addr(addr[0]), .i_sl_sel(sel[0]),
        .o_mem_valid(a_mem_valid), .i_mem_ready(mem_ready[0]), .o_mem_addr(a_mem_addr),
        .i_mem_rvalid(mem_rvalid[0]), .i_mem_rdata(mem_rdata[0][31:0]),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err)
    );

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .SUPPORT_MISALIGN(1'b0)) u_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(b_req_ready),
        .i_addr(addr[1]), .i_sl_sel(sel[1]),
        .o_mem_valid(b_mem_valid), .i_mem_ready(mem_ready[1]), .o_mem_addr(b_mem_addr),
        .i_mem_rvalid(mem_rvalid[1]), .i_mem_rdata(mem_rdata[1][31:0]),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err)
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(32), .SUPPORT_MISALIGN(1'b1)) u_c (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid[2]), .o_req_ready(c_req_ready),
        .i_addr(addr[2]), .i_sl_sel(sel[2]),
        .o_mem_valid(c_mem_valid), .i_mem_ready(mem_ready[2]), .o_mem_addr(c_mem_addr),
        .i_mem_rvalid(mem_rvalid[2]), .i_mem_rdata(mem_rdata[2]),
        .o_rsp_valid(c_rsp_valid), .i_rsp_ready(rsp_ready[2]),
        .o_rsp_data(c_rsp_data), .o_rsp_err(c_rsp_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic reqReady(input int k);
        case (k)
            0:       return a_req_ready;
            1:       return b_req_ready;
            default: return c_req_ready;
        endcase
    endfunction

    function automatic logic memValid(input int k);
        case (k)
            0:       return a_mem_valid;
            1:       return b_mem_valid;
            default: return c_mem_valid;
        endcase
    endfunction

    function automatic logic [31:0] memAddr(input int k);
        case (k)
            0:       return a_mem_addr;
            1:       return b_mem_addr;
            default: return c_mem_addr;
        endcase
    endfunction

    function automatic logic rspValid(input int k);
        case (k)
            0:       return a_rsp_valid;
            1:       return b_rsp_valid;
            default: return c_rsp_valid;
        endcase
    endfunction

    function automatic logic rspErr(input int k);
        case (k)
            0:       return a_rsp_err;
            1:       return b_rsp_err;
            default: return c_rsp_err;
        endcase
    endfunction

    function automatic logic [63:0] rspData(input int k);
        case (k)
            0:       return {32'h0, a_rsp_data};
            1:       return {32'h0, b_rsp_data};
            default: return c_rsp_data;
        endcase
    endfunction

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on a mismatch reports and counts the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    // Run one complete load on unit k with a zero-latency memory, optionally
    // holding off the read handshake and the response handshake. The step
    // structure fixes the response cycle: 3 after acceptance for one read,
    // 5 for a split access, plus any memory stall cycles.
    task automatic applyStimulus(input int k, input string tag,
                                 input logic [31:0] a, input logic [2:0] s,
                                 input logic [63:0] w0, input logic [63:0] w1,
                                 input int memStall, input int rspHold,
                                 input logic expErr, input logic expSplit,
                                 input logic [31:0] expAddr0, input logic [31:0] expAddr1,
                                 input logic [63:0] expData);
        checkOutput($sformatf("%s.idle_ready", tag), reqReady(k), 1'b1);
        req_valid[k] = 1'b1;
        addr[k]      = a;
        sel[k]       = s;
        step();
        req_valid[k] = 1'b0;
        if (!expErr) begin
            for (int i = 0; i < memStall; i++) begin
                checkOutput($sformatf("%s.rd0_stall_valid", tag), memValid(k), 1'b1);
                checkOutput($sformatf("%s.rd0_stall_addr", tag), memAddr(k), expAddr0);
                step();
            end
            checkOutput($sformatf("%s.rd0_valid", tag), memValid(k), 1'b1);
            checkOutput($sformatf("%s.rd0_addr", tag), memAddr(k), expAddr0);
            mem_ready[k] = 1'b1;
            step();
            mem_ready[k] = 1'b0;
            checkOutput($sformatf("%s.wait0_idle_bus", tag), memValid(k), 1'b0);
            checkOutput($sformatf("%s.wait0_no_rsp", tag), rspValid(k), 1'b0);
            mem_rvalid[k] = 1'b1;
            mem_rdata[k]  = w0;
            step();
            mem_rvalid[k] = 1'b0;
            mem_rdata[k]  = 64'h0;
            if (expSplit) begin
                checkOutput($sformatf("%s.rd1_valid", tag), memValid(k), 1'b1);
                checkOutput($sformatf("%s.rd1_addr", tag), memAddr(k), expAddr1);
                checkOutput($sformatf("%s.rd1_no_rsp", tag), rspValid(k), 1'b0);
                mem_ready[k] = 1'b1;
                step();
                mem_ready[k] = 1'b0;
                mem_rvalid[k] = 1'b1;
                mem_rdata[k]  = w1;
                step();
                mem_rvalid[k] = 1'b0;
                mem_rdata[k]  = 64'h0;
            end
        end
        for (int i = 0; i < rspHold; i++) begin
            checkOutput($sformatf("%s.hold_valid", tag), rspValid(k), 1'b1);
            checkOutput($sformatf("%s.hold_data", tag), rspData(k), expData);
            checkOutput($sformatf("%s.hold_busy", tag), reqReady(k), 1'b0);
            step();
        end
        checkOutput($sformatf("%s.rsp_valid", tag), rspValid(k), 1'b1);
        checkOutput($sformatf("%s.rsp_data", tag), rspData(k), expData);
        checkOutput($sformatf("%s.rsp_err", tag), rspErr(k), expErr);
        checkOutput($sformatf("%s.rsp_no_bus", tag), memValid(k), 1'b0);
        rsp_ready[k] = 1'b1;
        step();
        rsp_ready[k] = 1'b0;
        checkOutput($sformatf("%s.after_valid", tag), rspValid(k), 1'b0);
        checkOutput($sformatf("%s.after_data", tag), rspData(k), 64'h0);
        checkOutput($sformatf("%s.after_err", tag), rspErr(k), 1'b0);
        checkOutput($sformatf("%s.after_ready", tag), reqReady(k), 1'b1);
    endtask

    // Directed sequence: reset state, each select and alignment case,
    // stalls on both handshakes, address wrap, illegal requests, reset in
    // the middle of a split access, then the non-splitting and 64-bit units.
    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        mem_ready  = '0;
        mem_rvalid = '0;
        rsp_ready  = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k]      = 32'h0;
            sel[k]       = 3'b000;
            mem_rdata[k] = 64'h0;
        end
        step();
        step();
        checkOutput("reset.req_ready", a_req_ready, 1'b1);
        checkOutput("reset.mem_valid", a_mem_valid, 1'b0);
        checkOutput("reset.mem_addr", a_mem_addr, 32'h0);
        checkOutput("reset.rsp_valid", a_rsp_valid, 1'b0);
        checkOutput("reset.rsp_err", a_rsp_err, 1'b0);
        checkOutput("reset.rsp_data", a_rsp_data, 32'h0);
        rst_n = 1'b1;
        step();

        applyStimulus(0, "lb_1003", 32'h1003, 3'b000, 64'h80FF1234, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h1000, 32'h0, 64'hFFFFFF80);
        applyStimulus(0, "lhu_stall", 32'h1002, 3'b100, 64'hABCD0000, 64'h0,
                      3, 0, 1'b0, 1'b0, 32'h1000, 32'h0, 64'h0000ABCD);
        applyStimulus(0, "lw_split", 32'h1001, 3'b010, 64'h44332211, 64'h88776655,
                      0, 0, 1'b0, 1'b1, 32'h1000, 32'h1004, 64'h55443322);
        applyStimulus(0, "lh_split", 32'h1003, 3'b001, 64'hAA000000, 64'h000000FF,
                      0, 0, 1'b0, 1'b1, 32'h1000, 32'h1004, 64'hFFFFFFAA);
        applyStimulus(0, "sel111", 32'h1000, 3'b111, 64'h0, 64'h0,
                      0, 1, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
        applyStimulus(0, "lwu_on32", 32'h1000, 3'b101, 64'h0, 64'h0,
                      0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
        applyStimulus(0, "ld_on32", 32'h1000, 3'b110, 64'h0, 64'h0,
                      0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
        applyStimulus(0, "lw_wrap", 32'hFFFFFFFE, 3'b010, 64'hDDCCBBAA, 64'h44332211,
                      0, 4, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000000, 64'h2211DDCC);

        $display("[TB] reset during second read");
        req_valid[0] = 1'b1;
        addr[0]      = 32'h1003;
        sel[0]       = 3'b010;
        step();
        req_valid[0] = 1'b0;
        mem_ready[0] = 1'b1;
        step();
        mem_ready[0]  = 1'b0;
        mem_rvalid[0] = 1'b1;
        mem_rdata[0]  = 64'h11223344;
        step();
        mem_rvalid[0] = 1'b0;
        checkOutput("rst.rd1_addr", a_mem_addr, 32'h1004);
        mem_ready[0] = 1'b1;
        step();
        mem_ready[0] = 1'b0;
        checkOutput("rst.wait1_busy", a_req_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.req_ready", a_req_ready, 1'b1);
        checkOutput("rst.mem_valid", a_mem_valid, 1'b0);
        checkOutput("rst.mem_addr", a_mem_addr, 32'h0);
        checkOutput("rst.rsp_valid", a_rsp_valid, 1'b0);
        checkOutput("rst.rsp_err", a_rsp_err, 1'b0);
        checkOutput("rst.rsp_data", a_rsp_data, 32'h0);
        mem_rvalid[0] = 1'b1;
        mem_rdata[0]  = 64'hCAFEF00D;
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid[0] = 1'b0;
        mem_rdata[0]  = 64'h0;
        checkOutput("rst.stray_rsp", a_rsp_valid, 1'b0);
        checkOutput("rst.stray_bus", a_mem_valid, 1'b0);
        checkOutput("rst.stray_ready", a_req_ready, 1'b1);
        checkOutput("rst.stray_data", a_rsp_data, 32'h0);

        applyStimulus(0, "lbu_2000", 32'h2000, 3'b011, 64'h000000F0, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h2000, 32'h0, 64'h000000F0);

        applyStimulus(1, "nomis_lw1002", 32'h1002, 3'b010, 64'h0, 64'h0,
                      0, 2, 1'b1, 1'b0, 32'h0, 32'h0, 64'h0);
        applyStimulus(1, "nomis_lw1000", 32'h1000, 3'b010, 64'h12345678, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h1000, 32'h0, 64'h12345678);

        applyStimulus(2, "w64_lwu4", 32'h4, 3'b101, 64'h89ABCDEF00000000, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0000000089ABCDEF);
        applyStimulus(2, "w64_lw4", 32'h4, 3'b010, 64'hF000000012345678, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 64'hFFFFFFFFF0000000);
        applyStimulus(2, "w64_ld8", 32'h8, 3'b110, 64'h8000000000000001, 64'h0,
                      0, 0, 1'b0, 1'b0, 32'h8, 32'h0, 64'h8000000000000001);
        applyStimulus(2, "w64_lh_split", 32'hF, 3'b001, 64'h7F00000000000000, 64'h0000000000000080,
                      0, 0, 1'b0, 1'b1, 32'h8, 32'h10, 64'hFFFFFFFFFFFF807F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
